// File: rtl/clk_wiz_multi_clk_wiz_if.sv
// clk_wiz_multi_clk_wiz_if: enable/clock/lock bundle of the clock wizard.
// Master drives the enables; slave (the wizard) drives clocks and lock.
interface clk_wiz_multi_clk_wiz_if #(
  parameter int NUM_OUTS = 3
);
  logic [NUM_OUTS-1:0] clk_en;
  logic [NUM_OUTS-1:0] clk_out;
  logic                locked;

  modport master (
    output clk_en,
    input  clk_out,
    input  locked
  );

  modport slave (
    input  clk_en,
    output clk_out,
    output locked
  );
endinterface

// File: rtl/clk_wiz_multi_clk_wiz.sv
// clk_wiz_multi_clk_wiz: NUM_OUTS divided clocks with lock delay and enables.
// Optional macro CLK_WIZ_PHASE_EN adds PHASE_VEC per-channel start phase.
module clk_wiz_multi_clk_wiz #(
  parameter int NUM_OUTS = 3,
  parameter int DIV_W = 8,
  parameter logic [NUM_OUTS*DIV_W-1:0] DIV_VEC =
    {8'd8, 8'd4, 8'd2},
  parameter int LOCK_CYCLES = 16
`ifdef CLK_WIZ_PHASE_EN
  ,
  parameter logic [NUM_OUTS*DIV_W-1:0] PHASE_VEC = '0
`endif
) (
  input logic clk_in1,
  input logic reset,
  clk_wiz_multi_clk_wiz_if.slave bus
);

  localparam logic [15:0] LC_M1 = 16'(LOCK_CYCLES - 1);

  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
    $fatal(1, "LOCK_CYCLES out of range");
  end

  logic [15:0]         lock_cnt;
  logic                locked_q;
  logic [NUM_OUTS-1:0] out_w;

  // Lock delay: count edges after reset, then hold locked until reset.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      lock_cnt <= '0;
      locked_q <= 1'b0;
    end else if (!locked_q) begin
      if (lock_cnt == LC_M1) begin
        locked_q <= 1'b1;
      end else begin
        lock_cnt <= lock_cnt + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_OUTS; i++) begin : g_ch
    localparam int D = int'(DIV_VEC[i*DIV_W +: DIV_W]);

    if (D == 0) begin : g_bad_div
      $fatal(1, "divide ratio of 0 is illegal");
    end else if (D == 1) begin : g_d1
      logic en_q;

      // Divide-by-1: enable retimed every edge, clock gated through.
      always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
          en_q <= 1'b0;
        end else begin
          en_q <= bus.clk_en[i];
        end
      end

      assign out_w[i] = clk_in1 & locked_q & en_q;
    end else begin : g_div
`ifdef CLK_WIZ_PHASE_EN
      localparam int PH = int'(PHASE_VEC[i*DIV_W +: DIV_W]);
`else
      localparam int PH = 0;
`endif
      if (PH >= D) begin : g_bad_ph
        $fatal(1, "phase must be below divide ratio");
      end

      localparam logic [DIV_W-1:0] DM1 = DIV_W'(D - 1);
      localparam logic [DIV_W-1:0] HH  = DIV_W'(D / 2);
      localparam logic [DIV_W-1:0] PRE = DIV_W'((D - PH) % D);

      logic [DIV_W-1:0] cnt;
      logic             en_q;
      logic             q;

      // Period counter; enable captured only at period start.
      always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
          cnt  <= '0;
          en_q <= 1'b0;
          q    <= 1'b0;
        end else if (!locked_q) begin
          cnt <= PRE;
          q   <= 1'b0;
        end else begin
          cnt <= (cnt == DM1) ? '0 : cnt + DIV_W'(1);
          if (cnt == '0) begin
            en_q <= bus.clk_en[i];
          end
          q <= (cnt < HH) &&
               ((cnt == '0) ? bus.clk_en[i] : en_q);
        end
      end

      assign out_w[i] = q;
    end
  end

  assign bus.clk_out = out_w;
  assign bus.locked  = locked_q;

endmodule
